delay_arbiter: RTL

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter_pkg.sv | 16 +
 rtl/delay_arbiter_ticker.sv | 40 ++++
 rtl/delay_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/delay_arbiter_pkg.sv
// rtl/delay_arbiter_pkg.sv - shared constants for the delay arbiter
//
// Purpose : FSM state encoding and default parameter values used by
//           delay_arbiter and its ticker.
// Ports   : none (package).
package delay_arbiter_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int TICK_DIV_DEF = 100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/delay_arbiter_ticker.sv
// rtl/delay_arbiter_ticker.sv - free-running tick divider with hold-in-reset
//
// Purpose : emits a one-cycle tick every N_TICKS enabled clk cycles.
//           The tick is registered, so the first tick after leaving reset
//           appears N_TICKS cycles after the first enabled cycle.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset (clears phase and tick)
//           en   - count enable
//           tick - one-cycle pulse per N_TICKS enabled cycles
module delay_arbiter_ticker #(
    parameter int N_TICKS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == W'(N_TICKS - 1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// rtl/delay_arbiter.sv - round-robin arbiter sharing one tick timebase
//
// Purpose : serves NUM_REQ delay requests one at a time, timing each
//           granted delay in ticks of TICK_DIV clk cycles.
// Ports   : clk       - clock
//           rst       - synchronous active-high reset
//           req       - per-requester request level
//           delay     - packed delays, requester i at [i*CNT_W +: CNT_W]
//           grant     - one-hot, requester being timed (RUN only)
//           done      - one-hot one-cycle completion pulse
//           busy      - high whenever not IDLE
//           remaining - ticks left in the current delay, 0 outside RUN
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] delay,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         remaining
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [1:0]         state;
    logic [IDX_W-1:0]   cur;
    logic [IDX_W-1:0]   last;
    logic [CNT_W-1:0]   rem_q;
    logic [CNT_W-1:0]   dly [NUM_REQ];
    logic [NUM_REQ-1:0] cur_oh;
    logic               any_req;
    logic [IDX_W-1:0]   win;
    logic               tick;
    logic               tick_rst;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dly[g] = delay[g*CNT_W +: CNT_W];
    end

    // Round-robin: first requester found scanning last+1, last+2, ...
    // with wrap. sum never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
    always_comb begin
        logic [IDX_W:0] sum;
        any_req = 1'b0;
        win     = last;
        sum     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req && req[sum[IDX_W-1:0]]) begin
                any_req = 1'b1;
                win     = sum[IDX_W-1:0];
            end
        end
    end

    // Divider only runs in RUN, so every service starts at tick phase 0.
    assign tick_rst = rst | (state != ST_RUN);

    delay_arbiter_ticker #(
        .N_TICKS (TICK_DIV)
    ) u_ticker (
        .clk  (clk),
        .rst  (tick_rst),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= IDX_W'(NUM_REQ - 1);
            cur   <= '0;
            rem_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        cur   <= win;
                        rem_q <= dly[win];
                        state <= (dly[win] != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a completing tick in the same cycle.
                    if (!req[cur]) begin
                        state <= ST_IDLE;
                        rem_q <= '0;
                        last  <= cur;
                    end else if (tick) begin
                        if (rem_q == CNT_W'(1)) begin
                            state <= ST_DONE;
                            rem_q <= '0;
                        end else begin
                            rem_q <= rem_q - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    last  <= cur;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cur_oh    = NUM_REQ'(1) << cur;
    assign grant     = (state == ST_RUN)  ? cur_oh : '0;
    assign done      = (state == ST_DONE) ? cur_oh : '0;
    assign busy      = (state != ST_IDLE);
    assign remaining = (state == ST_RUN)  ? rem_q  : '0;

endmodule
